// File: rtl/sws_debounce_if.sv
// Switch-conditioner bus: raw inputs and sample qualifier in, clean level and edge pulses out.
interface sws_debounce_if #(
    parameter int unsigned WIDTH = 2
);
    logic [WIDTH-1:0] sw_in;
    logic             sample_en;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    // Producer of raw switch bits / consumer of debounced results.
    modport master (
        output sw_in,
        output sample_en,
        input  sw_out,
        input  rise,
        input  fall,
        input  changed
    );

    // The debouncer itself.
    modport slave (
        input  sw_in,
        input  sample_en,
        output sw_out,
        output rise,
        output fall,
        output changed
    );
endinterface

// File: rtl/sws_debounce.sv
// Slide-switch conditioner: per-channel synchroniser plus debounce FSM.
// Outputs are a registered debounced level and one-cycle rise/fall pulses,
// plus a registered "any channel changed" flag. The interface instance must
// be built with the same WIDTH as this module.
module sws_debounce #(
    parameter int unsigned     WIDTH         = 2,
    parameter int unsigned     SYNC_STAGES   = 2,
    parameter int unsigned     STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] INIT         = '0
) (
    input  logic          clk_in,
    input  logic          reset_n,
    sws_debounce_if.slave bus
);

    localparam int unsigned     CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW,
        ARM_HIGH,
        HIGH,
        ARM_LOW
    } state_t;

    logic [WIDTH-1:0] lvl_vec;
    logic [WIDTH-1:0] rise_vec;
    logic [WIDTH-1:0] fall_vec;
    logic [WIDTH-1:0] rise_nxt_vec;
    logic [WIDTH-1:0] fall_nxt_vec;
    logic             changed_q;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic                   s;
        state_t                 state;
        state_t                 state_nxt;
        logic [CW-1:0]          cnt;
        logic [CW-1:0]          cnt_nxt;
        logic                   lvl;
        logic                   lvl_nxt;
        logic                   rise_q;
        logic                   fall_q;
        logic                   rise_nxt;
        logic                   fall_nxt;

        assign s = sync[SYNC_STAGES-1];

        // Metastability chain; shifts every cycle regardless of sample_en.
        always_ff @(posedge clk_in) begin
            if (!reset_n) begin
                sync <= {SYNC_STAGES{INIT[g]}};
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], bus.sw_in[g]};
            end
        end

        // Debounce state, qualification counter, level and pulse registers.
        always_ff @(posedge clk_in) begin
            if (!reset_n) begin
                state  <= INIT[g] ? HIGH : LOW;
                cnt    <= '0;
                lvl    <= INIT[g];
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                state  <= state_nxt;
                cnt    <= cnt_nxt;
                lvl    <= lvl_nxt;
                rise_q <= rise_nxt;
                fall_q <= fall_nxt;
            end
        end

        // Next-state logic; only qualified samples advance the FSM.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            lvl_nxt   = lvl;
            rise_nxt  = 1'b0;
            fall_nxt  = 1'b0;
            if (bus.sample_en) begin
                unique case (state)
                    LOW: begin
                        if (s) begin
                            if (STABLE_CYCLES == 1) begin
                                state_nxt = HIGH;
                                lvl_nxt   = 1'b1;
                                rise_nxt  = 1'b1;
                            end else begin
                                state_nxt = ARM_HIGH;
                                cnt_nxt   = CW'(1);
                            end
                        end
                    end
                    ARM_HIGH: begin
                        if (!s) begin
                            state_nxt = LOW;
                            cnt_nxt   = '0;
                        end else if (cnt == CNT_LAST) begin
                            state_nxt = HIGH;
                            cnt_nxt   = '0;
                            lvl_nxt   = 1'b1;
                            rise_nxt  = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                    HIGH: begin
                        if (!s) begin
                            if (STABLE_CYCLES == 1) begin
                                state_nxt = LOW;
                                lvl_nxt   = 1'b0;
                                fall_nxt  = 1'b1;
                            end else begin
                                state_nxt = ARM_LOW;
                                cnt_nxt   = CW'(1);
                            end
                        end
                    end
                    ARM_LOW: begin
                        if (s) begin
                            state_nxt = HIGH;
                            cnt_nxt   = '0;
                        end else if (cnt == CNT_LAST) begin
                            state_nxt = LOW;
                            cnt_nxt   = '0;
                            lvl_nxt   = 1'b0;
                            fall_nxt  = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                endcase
            end
        end

        assign lvl_vec[g]      = lvl;
        assign rise_vec[g]     = rise_q;
        assign fall_vec[g]     = fall_q;
        assign rise_nxt_vec[g] = rise_nxt;
        assign fall_nxt_vec[g] = fall_nxt;
    end

    // Aggregate change flag, registered alongside the per-channel pulses.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |(rise_nxt_vec | fall_nxt_vec);
        end
    end

    assign bus.sw_out  = lvl_vec;
    assign bus.rise    = rise_vec;
    assign bus.fall    = fall_vec;
    assign bus.changed = changed_q;

endmodule

// File: tb/tb_sws_debounce.sv
// Testbench for sws_debounce: run-length reference model feeding a scoreboard,
// plus directed latency / pulse-count checks.
module tb_sws_debounce;

    localparam int unsigned     W      = 2;
    localparam int unsigned     SYNC   = 2;
    localparam int unsigned     STABLE = 4;
    localparam logic [W-1:0]    INIT   = '0;

    logic clk;
    logic rst_n;

    sws_debounce_if #(.WIDTH(W)) bus ();

    sws_debounce #(
        .WIDTH        (W),
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .INIT         (INIT)
    ) dut (
        .clk_in (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    // Expected {sw_out, rise, fall, changed} after each edge.
    logic [3*W:0] sb [$];

    // Reference model state: synchroniser copy, level, run of opposite samples.
    logic [SYNC-1:0] m_sync [W];
    logic [W-1:0]    m_lvl;
    int unsigned     m_run [W];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Predict outputs after the coming edge; a level is accepted once STABLE
    // consecutive qualified samples disagree with the current level.
    task automatic model_edge(input logic [W-1:0] sw, input logic en, input logic rst);
        logic [W-1:0] r;
        logic [W-1:0] f;
        r = '0;
        f = '0;
        if (!rst) begin
            for (int c = 0; c < W; c++) begin
                m_sync[c] = {SYNC{INIT[c]}};
                m_run[c]  = 0;
            end
            m_lvl = INIT;
        end else begin
            for (int c = 0; c < W; c++) begin
                if (en) begin
                    if (m_sync[c][SYNC-1] != m_lvl[c]) begin
                        m_run[c]++;
                        if (m_run[c] == STABLE) begin
                            m_lvl[c] = ~m_lvl[c];
                            m_run[c] = 0;
                            if (m_lvl[c]) r[c] = 1'b1;
                            else          f[c] = 1'b1;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
                m_sync[c] = {m_sync[c][SYNC-2:0], sw[c]};
            end
        end
        sb.push_back({m_lvl, r, f, |(r | f)});
    endtask

    // One clock: drive on negedge, predict, sample 1ns after posedge, compare.
    task automatic step(input logic [W-1:0] sw, input logic en, input logic rst);
        logic [3*W:0] exp;
        @(negedge clk);
        bus.sw_in     = sw;
        bus.sample_en = en;
        rst_n         = rst;
        model_edge(sw, en, rst);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            check("outs", 32'({bus.sw_out, bus.rise, bus.fall, bus.changed}), 32'(exp));
        end
    endtask

    int first;
    int pulses;
    logic [W-1:0] rsw;

    initial begin
        bus.sw_in     = '0;
        bus.sample_en = 1'b1;
        rst_n         = 1'b0;

        // Reset held 3 cycles with switches high, then release.
        for (int k = 0; k < 3; k++) step(2'b11, 1'b1, 1'b0);
        check("rst_sw_out", 32'(bus.sw_out), 32'(INIT));
        first = 0; pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            step(2'b11, 1'b1, 1'b1);
            if (bus.rise == 2'b11 && bus.changed) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        check("rst_rise_step", 32'(first), 32'd6);
        check("rst_rise_cnt", 32'(pulses), 32'd1);

        for (int k = 0; k < 8; k++) step(2'b00, 1'b1, 1'b1);
        check("both_low", 32'(bus.sw_out), 32'd0);

        // Clean rise then fall on channel 0.
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            step(2'b01, 1'b1, 1'b1);
            if (bus.rise[0] && first == 0) first = k;
        end
        check("clean_rise_step", 32'(first), 32'd6);
        check("clean_rise_gone", 32'(bus.rise), 32'd0);
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            step(2'b00, 1'b1, 1'b1);
            if (bus.fall[0] && first == 0) first = k;
        end
        check("clean_fall_step", 32'(first), 32'd6);

        // Bounce on channel 1: 1,1,1,0 then held high.
        first = 0; pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            step((k == 4) ? 2'b00 : 2'b10, 1'b1, 1'b1);
            if (bus.rise[1]) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        check("bounce_rise_step", 32'(first), 32'd10);
        check("bounce_rise_cnt", 32'(pulses), 32'd1);

        // Gated sampling on channel 0 with a glitch between qualified samples.
        first = 0; pulses = 0;
        for (int c = 0; c < 24; c++) begin
            step((c >= 6 && c <= 8) ? 2'b10 : 2'b11, (c % 4) == 3, 1'b1);
            if (bus.rise[0]) begin
                pulses++;
                if (first == 0) first = c + 1;
            end
        end
        check("gated_rise_step", 32'(first), 32'd16);
        check("gated_rise_cnt", 32'(pulses), 32'd1);

        // Both channels together.
        for (int k = 0; k < 10; k++) step(2'b00, 1'b1, 1'b1);
        first = 0; pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            step(2'b11, 1'b1, 1'b1);
            if (bus.changed) begin
                pulses++;
                if (bus.rise == 2'b11 && first == 0) first = k;
            end
        end
        check("simul_rise_step", 32'(first), 32'd6);
        check("simul_changed_cnt", 32'(pulses), 32'd1);

        // Reset while channel 0 is arming.
        for (int k = 0; k < 10; k++) step(2'b00, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(2'b01, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b0);
        check("midarm_sw_out", 32'(bus.sw_out), 32'd0);
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            step(2'b01, 1'b1, 1'b1);
            if (bus.rise[0] && first == 0) first = k;
        end
        check("midarm_rise_step", 32'(first), 32'd6);

        // Random soak against the model: slow-changing inputs, random gating and resets.
        rsw = '0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0) rsw = W'($urandom);
            step(rsw, $urandom_range(0, 3) != 0, $urandom_range(0, 60) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sws_debounce.md
# sws_debounce

Input conditioner for the board slide switches (and any other slow mechanical inputs). It sits directly upstream of the LED/BRAM counter logic and replaces raw switch bits (`sws_2bits_tri_i`) as the source of count-enable and count-direction. Each channel gets a metastability synchroniser and a per-channel debounce FSM. Outputs are a clean registered level plus one-cycle rise/fall pulses.

## Interface
- `WIDTH`, 2: number of independent input channels.
- `SYNC_STAGES`, 2: synchroniser flop depth, ≥2.
- `STABLE_CYCLES`, 4: consecutive qualified samples required to accept a new level, ≥1.
- `INIT`, {WIDTH{1'b0}}: per-channel reset level of synchroniser, FSM and `sw_out`.

Ports:
- `clk_in`  in  1  sole clock; all state on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `sw_in`  in  WIDTH  raw asynchronous switch inputs.
- `sample_en`  in  1  qualifies FSM/counter advance; tie 1 for every-cycle sampling.
- `sw_out`  out  WIDTH  debounced level, registered.
- `rise`  out  WIDTH  one-cycle pulse when `sw_out[i]` goes 0→1.
- `fall`  out  WIDTH  one-cycle pulse when `sw_out[i]` goes 1→0.
- `changed`  out  1  registered OR of all `rise` and `fall` bits, same cycle.

## Operation
- Synchroniser: `SYNC_STAGES`-deep shift chain per channel. It runs every cycle regardless of `sample_en`. Its last stage is `s[i]`.
- Per-channel FSM states: `LOW`, `ARM_HIGH`, `HIGH`, `ARM_LOW`. There is one counter per channel, `cnt`, width $clog2(STABLE_CYCLES+1). The FSM and counter change only on edges with `sample_en`=1. Otherwise state and `cnt` hold, and `rise`/`fall` are 0.
- `LOW` (`sw_out`=0):
  - `s`=0: stay.
  - `s`=1: if `STABLE_CYCLES`==1, go to `HIGH` and commit. Otherwise go to `ARM_HIGH` with `cnt`=1.
- `ARM_HIGH`:
  - `s`=0: bounce. Return to `LOW`, `cnt`=0, no pulse.
  - `s`=1 and `cnt`==`STABLE_CYCLES`-1: go to `HIGH` and commit.
  - Otherwise: `cnt`+1.
- `HIGH` and `ARM_LOW` mirror `LOW` and `ARM_HIGH` with polarity inverted.
- Commit means, on the same edge: `sw_out[i]` flips, the matching `rise[i]` or `fall[i]` is 1 for exactly one cycle, and `cnt`=0.
- `cnt` never exceeds `STABLE_CYCLES`-1 and never wraps.
- Channels are fully independent. Several channels may commit on the same edge; `changed`=1 once for that cycle.
- Reset (`reset_n`=0 at an edge):
  - synchroniser stages, `sw_out` ← `INIT`;
  - FSM ← `LOW`/`HIGH` per `INIT` bit;
  - `cnt`, `rise`, `fall`, `changed` ← 0.
- Reset overrides everything, including an armed channel mid-count. No pulse is ever produced by reset or on the first cycle after it.
- `rise` and `fall` of one channel are never 1 in the same cycle.

## Timing
- Reset values: `sw_out`=`INIT`; `rise`=0, `fall`=0, `changed`=0.
- Latency with `sample_en`=1 constantly: a new level captured into stage 1 at edge E0 appears on `sw_out` and the pulse at edge E0+`SYNC_STAGES`+`STABLE_CYCLES`-1. With defaults this is E0+5.
- Acceptance: the new level must be present for `STABLE_CYCLES` consecutive qualified samples of `s`. Any opposite sample in between restarts qualification from zero.
- With `sample_en` gated, latency counts qualified samples, not cycles. Input activity between qualified samples is invisible to the FSM.
- All outputs come straight from flops; there is no combinational path from `sw_in` or `sample_en` to any output.
- Throughput: the minimum spacing between two commits on one channel is `STABLE_CYCLES` qualified samples.

## Test plan
- Reset, defaults, `INIT`=0: hold `reset_n`=0 for 3 cycles with `sw_in`=2'b11 → `sw_out`=0 and no pulses during and for 1 cycle after release. With `sw_in` held at 2'b11, `rise`=2'b11 and `changed`=1 together, one cycle only, at the 6th edge after release (E0=first edge after release, pulse at E0+5).
- Clean edge: `sw_in[0]` 0→1 captured at E0 → `sw_out[0]`=1 and `rise[0]`=1 at E0+5; `rise[0]`=0 at E0+6. Then 1→0 → `fall[0]` after the same latency.
- Bounce rejection: `sw_in[1]` pattern 1,1,1,0,1,1,1,1 → no commit on the first run of three. `sw_out[1]` rises 5 edges after the final run begins; exactly one `rise[1]` pulse.
- `sample_en` gating: `sample_en` high every 4th cycle, `sw_in[0]` held high → commit on the 4th qualified sample after `s` goes high. A 3-cycle low glitch between qualified samples does not restart qualification.
- Simultaneous channels: both channels toggle together → `rise`=2'b11 in one cycle, `changed` high for exactly that one cycle.
- Reset mid-arm: `sw_in[0]` high for 4 cycles, then `reset_n`=0 for 1 edge, `sw_in` still high → `sw_out[0]`=0 after reset, and full latency applies again from release.
